// File: rtl/capture_sequencer.sv
// capture_sequencer: arms the FIFO datapath, waits out pre-trigger fill, accepts a trigger,
// applies the trigger delay and runs the capture until the datapath reports completion.
module capture_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             adc_sampleclk,
    input  logic             reset_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] trig_delay_i,
    input  logic [CNT_W-1:0] presample_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic             capture_stop_i,
    output logic             arm_o,
    output logic             capture_go_o,
    output logic             capture_armed_o,
    output logic             trig_status_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [2:0]       state_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMING  = 3'd1,
        ARMED   = 3'd2,
        DELAY   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             arm_q, trig_q;
    logic             arm_edge, trig_acc;
    logic             trig_status_n, timeout_n;

    assign arm_edge = arm_i & ~arm_q;
    assign trig_acc = capture_armed_o & trig_i & ~trig_q;
    assign state_o  = state;

    always_comb begin
        state_n       = state;
        trig_status_n = trig_status_o;
        timeout_n     = timeout_o;
        case (state)
            IDLE: if (arm_edge) begin
                state_n       = ARMING;
                trig_status_n = 1'b0;
                timeout_n     = 1'b0;
            end
            ARMING: if (cnt == CNT_W'(3)) state_n = ARMED;
            ARMED: if (trig_acc) begin
                state_n       = (trig_delay_i == '0) ? CAPTURE : DELAY;
                trig_status_n = 1'b1;
            end else if (timeout_i != '0 && cnt == timeout_i - CNT_W'(1)) begin
                state_n   = DONE;
                timeout_n = 1'b1;
            end
            DELAY:   if (cnt == trig_delay_i - CNT_W'(1)) state_n = CAPTURE;
            CAPTURE: if (capture_stop_i) state_n = DONE;
            DONE:    if (!arm_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort wins over every other event, including a trigger or stop in the same cycle
        if (abort_i && state != IDLE) begin
            state_n       = IDLE;
            trig_status_n = 1'b0;
            timeout_n     = 1'b0;
        end
        cnt_n = (state_n != state) ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
    end

    // outputs are registered from next-state values so they line up with state_o
    always_ff @(posedge adc_sampleclk or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            cnt             <= '0;
            arm_q           <= 1'b1;
            trig_q          <= 1'b1;
            arm_o           <= 1'b0;
            capture_go_o    <= 1'b0;
            capture_armed_o <= 1'b0;
            trig_status_o   <= 1'b0;
            done_o          <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            arm_q           <= arm_i;
            trig_q          <= trig_i;
            arm_o           <= state_n inside {ARMING, ARMED, DELAY, CAPTURE};
            capture_go_o    <= state_n == CAPTURE;
            capture_armed_o <= state_n == ARMED && cnt_n >= presample_i;
            trig_status_o   <= trig_status_n;
            done_o          <= state_n == DONE;
            timeout_o       <= timeout_n;
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed checks of arming, pre-trigger fill, delay, timeout, abort and reset.
module tb_capture_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm_i = 1'b0, abort_i = 1'b0, trig_i = 1'b0, capture_stop_i = 1'b0;
    logic [31:0] trig_delay_i = '0, presample_i = '0, timeout_i = '0;
    logic        arm_o, capture_go_o, capture_armed_o, trig_status_o, done_o, timeout_o;
    logic [2:0]  state_o;
    logic        go_seen;
    int          checks = 0;
    int          errors = 0;

    capture_sequencer #(.CNT_W(32)) dut (
        .adc_sampleclk  (clk),
        .reset_i        (rst),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .trig_i         (trig_i),
        .trig_delay_i   (trig_delay_i),
        .presample_i    (presample_i),
        .timeout_i      (timeout_i),
        .capture_stop_i (capture_stop_i),
        .arm_o          (arm_o),
        .capture_go_o   (capture_go_o),
        .capture_armed_o(capture_armed_o),
        .trig_status_o  (trig_status_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (capture_go_o) go_seen <= 1'b1;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // raise arm_i from low and walk through the 4 ARMING cycles; returns at ARMED count 0
    task automatic arm_seq(input string tag);
        arm_i = 1'b0;
        tick();
        arm_i = 1'b1;
        tick();
        chk3({tag, "_arming"}, state_o, 3'd1);
        chk1({tag, "_arm_o"}, arm_o, 1'b1);
        chk1({tag, "_trig_clr"}, trig_status_o, 1'b0);
        chk1({tag, "_tmo_clr"}, timeout_o, 1'b0);
        tick(3);
        chk3({tag, "_arming4"}, state_o, 3'd1);
        tick();
        chk3({tag, "_armed"}, state_o, 3'd2);
    endtask

    initial begin
        #2;
        chk3("rst_state", state_o, 3'd0);
        chk1("rst_arm_o", arm_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // basic capture
        presample_i = 32'd10;
        arm_seq("basic");
        tick(9);
        chk1("basic_fill9", capture_armed_o, 1'b0);
        tick();
        chk1("basic_fill10", capture_armed_o, 1'b1);
        tick(10);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        chk3("basic_cap_state", state_o, 3'd4);
        chk1("basic_go", capture_go_o, 1'b1);
        chk1("basic_trig", trig_status_o, 1'b1);
        capture_stop_i = 1'b1;
        tick();
        capture_stop_i = 1'b0;
        chk3("basic_done_state", state_o, 3'd5);
        chk1("basic_done", done_o, 1'b1);
        chk1("basic_go_off", capture_go_o, 1'b0);
        chk1("basic_done_trig", trig_status_o, 1'b1);
        chk1("basic_done_arm_o", arm_o, 1'b0);
        tick();
        chk1("basic_done_hold", done_o, 1'b1);
        arm_i = 1'b0;
        tick();
        chk3("basic_idle", state_o, 3'd0);
        chk1("basic_done_fall", done_o, 1'b0);

        // early trigger ignored during fill
        presample_i = 32'd50;
        arm_seq("early");
        tick(30);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        chk3("early_ignored", state_o, 3'd2);
        chk1("early_no_go", capture_go_o, 1'b0);
        chk1("early_no_trig", trig_status_o, 1'b0);
        tick(29);
        chk1("early_armed60", capture_armed_o, 1'b1);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        chk1("early_go", capture_go_o, 1'b1);
        capture_stop_i = 1'b1;
        tick();
        capture_stop_i = 1'b0;
        chk1("early_done", done_o, 1'b1);
        arm_i = 1'b0;
        tick();

        // trigger delay, then abort and stop together
        presample_i  = 32'd0;
        trig_delay_i = 32'd5;
        arm_seq("delay");
        chk1("delay_armed0", capture_armed_o, 1'b1);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        chk3("delay_state", state_o, 3'd3);
        chk1("delay_trig", trig_status_o, 1'b1);
        tick(4);
        chk1("delay_go5", capture_go_o, 1'b0);
        tick();
        chk1("delay_go6", capture_go_o, 1'b1);
        abort_i        = 1'b1;
        capture_stop_i = 1'b1;
        tick();
        abort_i        = 1'b0;
        capture_stop_i = 1'b0;
        chk3("abort_state", state_o, 3'd0);
        chk1("abort_done", done_o, 1'b0);
        chk1("abort_go", capture_go_o, 1'b0);
        chk1("abort_arm_o", arm_o, 1'b0);
        chk1("abort_trig", trig_status_o, 1'b0);
        tick(2);
        chk3("abort_stay_idle", state_o, 3'd0);

        // timeout with no trigger
        trig_delay_i = 32'd0;
        timeout_i    = 32'd100;
        go_seen      = 1'b0;
        arm_seq("tmo");
        tick(99);
        chk3("tmo_armed99", state_o, 3'd2);
        tick();
        chk3("tmo_done_state", state_o, 3'd5);
        chk1("tmo_flag", timeout_o, 1'b1);
        chk1("tmo_done", done_o, 1'b1);
        chk1("tmo_trig", trig_status_o, 1'b0);
        chk1("tmo_go_seen", go_seen, 1'b0);
        arm_i = 1'b0;
        tick();

        // trigger on the timeout cycle wins
        arm_seq("race");
        tick(99);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        chk3("race_state", state_o, 3'd4);
        chk1("race_go", capture_go_o, 1'b1);
        chk1("race_tmo", timeout_o, 1'b0);
        capture_stop_i = 1'b1;
        tick();
        capture_stop_i = 1'b0;
        arm_i = 1'b0;
        tick();

        // reset during DELAY, then re-arm rules
        timeout_i    = 32'd0;
        trig_delay_i = 32'd5;
        arm_seq("rst");
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        tick(2);
        chk3("rst_in_delay", state_o, 3'd3);
        rst = 1'b1;
        #1;
        chk1("rst_async_arm_o", arm_o, 1'b0);
        chk3("rst_async_state", state_o, 3'd0);
        chk1("rst_async_trig", trig_status_o, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk3("rst_arm_high_idle", state_o, 3'd0);
        chk1("rst_no_done", done_o, 1'b0);
        arm_i = 1'b0;
        tick();
        arm_i = 1'b1;
        tick();
        chk3("rst_rearm", state_o, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
